ingress_port_queue: RTL and testbench

Per-port ingress queue sitting directly upstream of `switch_module`. It accepts framed words from one external port, checks framing and destination, buffers up to `DEPTH` words and presents them in order on the switch's per-port `rx` slice with a valid/ready handshake. One instance exists per port; its `rx` output drives `rx_total[(PORT_ID+1)*DATA_WIDTH-1 : PORT_ID*DATA_WIDTH]`.

---
 rtl/ingress_port_queue_pkg.sv | 39 +++
 rtl/ingress_port_queue_sync_fifo.sv | 55 +++++
 rtl/ingress_port_queue.sv | 148 ++++++++++++++
 tb/tb_ingress_port_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_port_queue_pkg.sv
//------------------------------------------------------------------------------
// ingress_port_queue_pkg
// Shared widths, input FSM encoding and FIFO entry layout {dest, sop, eop, data}.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ingress_port_queue_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int PORT_NUB_TOTAL = 4;
  localparam int DEST_W         = $clog2(PORT_NUB_TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } in_state_t;

  // Entry offsets are shared with the switch-side unpacking.
  function automatic int entry_eop_bit(input int dw);
    return dw;
  endfunction

  function automatic int entry_sop_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int entry_dest_lsb(input int dw);
    return dw + 2;
  endfunction

  function automatic int entry_width(input int dw, input int destw);
    return dw + 2 + destw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ingress_port_queue_sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
// First-word fall-through FIFO built from flops, with occupancy output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Storage is reset so the read port shows zero until the first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (pop && !empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign level = r_wptr - r_rptr;
  assign rdata = r_mem[r_rptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/ingress_port_queue.sv
//------------------------------------------------------------------------------
// ingress_port_queue
// Per-port framing/destination check and FIFO feeding the switch rx slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ingress_port_queue #(
  parameter int DATA_WIDTH     = ingress_port_queue_pkg::DATA_WIDTH,
  parameter int PORT_NUB_TOTAL = ingress_port_queue_pkg::PORT_NUB_TOTAL,
  parameter int PORT_ID        = 0,
  parameter int DEPTH          = 16,
  parameter int DEST_W         = $clog2(PORT_NUB_TOTAL)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [DEST_W-1:0]         in_dest,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [DATA_WIDTH-1:0]     rx,
  output logic                      rx_sop,
  output logic                      rx_eop,
  output logic [DEST_W-1:0]         rx_dest,
  output logic [15:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  import ingress_port_queue_pkg::*;

  localparam int EOP_BIT  = entry_eop_bit(DATA_WIDTH);
  localparam int SOP_BIT  = entry_sop_bit(DATA_WIDTH);
  localparam int DEST_LSB = entry_dest_lsb(DATA_WIDTH);
  localparam int ENTRY_W  = entry_width(DATA_WIDTH, DEST_W);
  localparam logic [DEST_W-1:0] C_PORT_ID = DEST_W'(PORT_ID);

  in_state_t             r_state;
  logic                  r_init;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic [DEST_W-1:0]     r_dest;
  logic [15:0]           r_drop_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_truncate;
  logic                  w_drop_discard;
  logic                  w_in_xfer;
  logic                  w_push;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_wentry;
  logic [ENTRY_W-1:0]    w_rentry;

  // A new sop inside PASS is held off for one cycle while the marker entry closes the old frame.
  assign w_truncate     = (r_state == ST_PASS) && in_valid && in_sop;
  assign w_drop_discard = (r_state == ST_DROP) && !(in_sop && (in_dest != C_PORT_ID));
  assign in_ready       = r_init && (w_drop_discard || (!w_full && !w_truncate));
  assign w_in_xfer      = in_valid && in_ready;

  always_comb begin
    w_push                        = 1'b0;
    w_drop                        = 1'b0;
    w_wentry                      = '0;
    w_wentry[DATA_WIDTH-1:0]      = in_data;
    w_wentry[EOP_BIT]             = in_eop;
    w_wentry[SOP_BIT]             = in_sop;
    w_wentry[DEST_LSB +: DEST_W]  = in_sop ? in_dest : r_dest;
    if (w_truncate && !w_full) begin
      w_push                       = 1'b1;
      w_drop                       = 1'b1;
      w_wentry[DATA_WIDTH-1:0]     = r_last_data;
      w_wentry[EOP_BIT]            = 1'b1;
      w_wentry[SOP_BIT]            = 1'b0;
      w_wentry[DEST_LSB +: DEST_W] = r_dest;
    end else if (w_in_xfer) begin
      if (r_state == ST_PASS) begin
        w_push = 1'b1;
      end else if (in_sop) begin
        w_push = (in_dest != C_PORT_ID);
        w_drop = (in_dest == C_PORT_ID);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_init      <= 1'b0;
      r_last_data <= '0;
      r_dest      <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_truncate && !w_full) begin
        r_state <= ST_IDLE;
      end else if (w_in_xfer) begin
        case (r_state)
          ST_PASS: begin
            r_last_data <= in_data;
            if (in_eop) r_state <= ST_IDLE;
          end
          default: begin
            if (in_sop && (in_dest == C_PORT_ID)) begin
              r_state <= in_eop ? ST_IDLE : ST_DROP;
            end else if (in_sop) begin
              r_dest      <= in_dest;
              r_last_data <= in_data;
              r_state     <= in_eop ? ST_IDLE : ST_PASS;
            end else if ((r_state == ST_DROP) && in_eop) begin
              r_state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wentry),
    .pop   (rx_ready),
    .full  (w_full),
    .empty (w_empty),
    .rdata (w_rentry),
    .level (level)
  );

  assign rx_valid = !w_empty;
  assign rx       = w_rentry[DATA_WIDTH-1:0];
  assign rx_eop   = w_rentry[EOP_BIT];
  assign rx_sop   = w_rentry[SOP_BIT];
  assign rx_dest  = w_rentry[DEST_LSB +: DEST_W];
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ingress_port_queue.sv
//------------------------------------------------------------------------------
// tb_ingress_port_queue
// Directed bench: framing, loopback drop, back-pressure, truncation, reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ingress_port_queue;

  localparam int DW = 8;
  localparam int DEST_W = 2;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_sop;
  logic              in_eop;
  logic [DEST_W-1:0] in_dest;
  logic              rx_valid;
  logic              rx_ready;
  logic [DW-1:0]     rx;
  logic              rx_sop;
  logic              rx_eop;
  logic [DEST_W-1:0] rx_dest;
  logic [15:0]       drop_cnt;
  logic [4:0]        level;

  int checks = 0;
  int errors = 0;
  logic [11:0] outq[$];

  ingress_port_queue #(
    .DATA_WIDTH     (DW),
    .PORT_NUB_TOTAL (4),
    .PORT_ID        (0),
    .DEPTH          (DEPTH),
    .DEST_W         (DEST_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_dest  (in_dest),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx       (rx),
    .rx_sop   (rx_sop),
    .rx_eop   (rx_eop),
    .rx_dest  (rx_dest),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Output words as {dest, sop, eop, data}, captured at each accepted transfer.
  always @(posedge clk) begin
    if (rst_n && rx_valid && rx_ready) outq.push_back({rx_dest, rx_sop, rx_eop, rx});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] d, input logic s,
                           input logic e, input logic [7:0] data);
    logic [11:0] got;
    got = 12'hFFF;
    if (outq.size() != 0) got = outq.pop_front();
    check(tag, {20'd0, got}, {20'd0, d, s, e, data});
  endtask

  task automatic send(input logic s, input logic e, input logic [1:0] d, input logic [7:0] data);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_dest  = d;
    in_data  = data;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      errors++;
      $display("FAIL send_timeout: observed in_ready=0 expected 1 (data %h)", data);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_dest  = '0;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx", {24'd0, rx}, 32'd0);
    check("rst_rx_flags", {28'd0, rx_sop, rx_eop, rx_dest}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Basic 4-word frame, first word visible one edge after acceptance
    send(1'b1, 1'b0, 2'd3, 8'hA1);
    check("lat_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("lat_rx", {24'd0, rx}, 32'hA1);
    send(1'b0, 1'b0, 2'd3, 8'hA2);
    send(1'b0, 1'b0, 2'd3, 8'hA3);
    send(1'b0, 1'b1, 2'd3, 8'hA4);
    idle(4);
    check("f1_count", outq.size(), 32'd4);
    check_out("f1_w0", 2'd3, 1'b1, 1'b0, 8'hA1);
    check_out("f1_w1", 2'd3, 1'b0, 1'b0, 8'hA2);
    check_out("f1_w2", 2'd3, 1'b0, 1'b0, 8'hA3);
    check_out("f1_w3", 2'd3, 1'b0, 1'b1, 8'hA4);

    // Loopback frame dropped, next frame passes
    send(1'b1, 1'b0, 2'd0, 8'hB1);
    send(1'b0, 1'b0, 2'd0, 8'hB2);
    send(1'b0, 1'b1, 2'd0, 8'hB3);
    send(1'b1, 1'b1, 2'd2, 8'hC1);
    idle(4);
    check("lb_count", outq.size(), 32'd1);
    check_out("lb_next", 2'd2, 1'b1, 1'b1, 8'hC1);
    check("lb_drop_cnt", {16'd0, drop_cnt}, 32'd1);

    // Back-pressure: 16 accepted, then stall, then drain all 20
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i == 0, 1'b0, 2'd1, 8'hD0 + 8'(i));
    in_data = 8'hD0 + 8'd16;
    in_sop  = 1'b0;
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_level", {27'd0, level}, 32'd16);
    @(negedge clk);
    check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
    check("bp_nothing_out", outq.size(), 32'd0);
    rx_ready = 1'b1;
    for (int i = 16; i < 20; i++) send(1'b0, i == 19, 2'd1, 8'hD0 + 8'(i));
    idle(24);
    check("bp_count", outq.size(), 32'd20);
    for (int i = 0; i < 20; i++) check_out("bp_word", 2'd1, i == 0, i == 19, 8'hD0 + 8'(i));

    // Truncated frame closed by a marker entry; new frame intact
    send(1'b1, 1'b0, 2'd2, 8'hE1);
    send(1'b0, 1'b0, 2'd2, 8'hE2);
    send(1'b1, 1'b0, 2'd1, 8'hF1);
    send(1'b0, 1'b1, 2'd1, 8'hF2);
    idle(4);
    check("tr_count", outq.size(), 32'd5);
    check_out("tr_e1", 2'd2, 1'b1, 1'b0, 8'hE1);
    check_out("tr_e2", 2'd2, 1'b0, 1'b0, 8'hE2);
    check_out("tr_marker", 2'd2, 1'b0, 1'b1, 8'hE2);
    check_out("tr_f1", 2'd1, 1'b1, 1'b0, 8'hF1);
    check_out("tr_f2", 2'd1, 1'b0, 1'b1, 8'hF2);
    check("tr_drop_cnt", {16'd0, drop_cnt}, 32'd2);

    // Stray words without sop in IDLE
    send(1'b0, 1'b0, 2'd3, 8'h55);
    send(1'b0, 1'b1, 2'd3, 8'h66);
    idle(3);
    check("stray_count", outq.size(), 32'd0);
    check("stray_drop_cnt", {16'd0, drop_cnt}, 32'd2);

    // Asynchronous reset with five words queued
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i == 0, i == 4, 2'd3, 8'h70 + 8'(i));
    idle(1);
    check("ar_level_before", {27'd0, level}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("ar_level", {27'd0, level}, 32'd0);
    check("ar_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    send(1'b1, 1'b0, 2'd1, 8'h91);
    send(1'b0, 1'b1, 2'd1, 8'h92);
    idle(4);
    check("ar_count", outq.size(), 32'd2);
    check_out("ar_w0", 2'd1, 1'b1, 1'b0, 8'h91);
    check_out("ar_w1", 2'd1, 1'b0, 1'b1, 8'h92);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
